// File: rtl/pb_mode_ctrl_pkg.sv
// Shared constants for the push-button mode controller: FSM encodings and
// default timing so the debounce and control stages agree on the clk_d rate.
package pb_mode_ctrl_pkg;

    localparam int unsigned StateW = 2;

    localparam logic [StateW-1:0] StIdle  = 2'd0;
    localparam logic [StateW-1:0] StPress = 2'd1;
    localparam logic [StateW-1:0] StHeld  = 2'd2;

    localparam int unsigned HoldCyclesDef = 100;
    localparam int unsigned CntWDef       = 8;

endpackage

// File: rtl/pb_mode_ctrl.sv
// Push-button mode controller: classifies debounced presses as short or long,
// emits registered one-cycle pulses and maintains the stopwatch run state.
module pb_mode_ctrl
    import pb_mode_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = HoldCyclesDef,
    parameter int unsigned CNT_W       = CntWDef
) (
    input  logic              clk_d,
    input  logic              rst,
    input  logic              pb_cs,
    output logic              press_pulse,
    output logic              short_pulse,
    output logic              long_pulse,
    output logic              run_en,
    output logic [StateW-1:0] state_dbg
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(HOLD_CYCLES - 1);

    logic [StateW-1:0] state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              press_q, press_d;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic              run_q, run_d;

    // Next-state, hold counter and pulse decode; pulses default low every cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        run_d   = run_q;
        case (state_q)
            StIdle: begin
                if (pb_cs) begin
                    state_d = StPress;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            StPress: begin
                // Release wins over reaching the long threshold on the same sample.
                if (!pb_cs) begin
                    state_d = StIdle;
                    short_d = 1'b1;
                    run_d   = ~run_q;
                end else if (cnt_q == CntLast) begin
                    state_d = StHeld;
                    long_d  = 1'b1;
                    run_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StHeld: begin
                if (!pb_cs) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_d or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            press_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            short_q <= short_d;
            long_q  <= long_d;
            run_q   <= run_d;
        end
    end

    assign press_pulse = press_q;
    assign short_pulse = short_q;
    assign long_pulse  = long_q;
    assign run_en      = run_q;
    assign state_dbg   = state_q;

endmodule
